anc_fir_mac: RTL and testbench

//  Sequential N-tap FIR multiply-accumulate for the ANC filter path; one multiplier time-shared over all taps.

---
 rtl/anc_pkg.sv | 20 ++
 rtl/anc_fir_mac_if.sv | 31 +++
 rtl/anc_mult_s32.sv | 15 +
 rtl/anc_fir_mac.sv | 158 +++++++++++++++
 tb/tb_anc_fir_mac.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/anc_pkg.sv
// Shared constants and FSM state type for the ANC FIR multiply-accumulate.
// No ports; imported by the interface, the multiplier and the top.
package anc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned COEF_W = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed 64-bit clip limits for the optional saturating output.
  localparam logic [PROD_W-1:0] SAT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [PROD_W-1:0] SAT_MIN = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/anc_fir_mac_if.sv
// Bus interface of the ANC FIR MAC.
// master: drives sample strobe, coefficient writes and overrun clear; receives
//         filter output, output strobe and status.
// slave : the filter side of the same signals.
interface anc_fir_mac_if
  import anc_pkg::*;
  ();

  logic signed [DATA_W-1:0] x_in;
  logic                     x_valid;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     clr_ovr;
  logic signed [PROD_W-1:0] y_out;
  logic                     y_valid;
  logic                     busy;
  logic                     overrun;
  logic                     sat_flag;

  modport master (
    output x_in, x_valid, coef_we, coef_addr, coef_data, clr_ovr,
    input  y_out, y_valid, busy, overrun, sat_flag
  );

  modport slave (
    input  x_in, x_valid, coef_we, coef_addr, coef_data, clr_ovr,
    output y_out, y_valid, busy, overrun, sat_flag
  );

endinterface

// File: rtl/anc_mult_s32.sv
// Combinational signed 32x32 -> 64 multiplier, kept separate so the DSP
// mapping is isolated from the accumulator logic.
// Ports: a (signed sample), b (signed coefficient), prod_c (full product).
module anc_mult_s32
  import anc_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [PROD_W-1:0] prod_c
);

  // Sign-extend both operands to the product width; the low 64 bits are exact.
  always_comb prod_c = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/anc_fir_mac.sv
// Sequential N-tap FIR for the ANC filter path: one multiplier shared over all
// taps, one 64-bit result per accepted sample.
// Ports: clk, rst (synchronous, active high), bus (anc_fir_mac_if.slave):
//   x_in/x_valid sample in, coef_we/coef_addr/coef_data coefficient write,
//   clr_ovr overrun clear, y_out/y_valid result, busy, overrun (sticky),
//   sat_flag (clip indication).
// Optional macro ANC_MAC_SAT_EN: clip result to signed 64 bits and pulse
//   sat_flag; otherwise the result wraps and sat_flag stays 0.
module anc_fir_mac
  import anc_pkg::*;
#(
  parameter int unsigned NTAPS = 16
) (
  input  logic          clk,
  input  logic          rst,
  anc_fir_mac_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NTAPS);
  localparam int unsigned ACC_W = PROD_W + IDX_W;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] tap_q  [NTAPS];
  logic signed [DATA_W-1:0] tap_d  [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];
  logic signed [PROD_W-1:0] y_out_q, y_out_d;
  logic                     y_valid_q, y_valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic                     sat_flag_q, sat_flag_d;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] result_c;
  logic                     clip_c;

  // Shared multiplier reads the registered taps/coefs, so a same-cycle
  // coefficient write is seen only from the next MAC step onward.
  anc_mult_s32 u_mult (
    .a      (tap_q[idx_q]),
    .b      (coef_q[idx_q]),
    .prod_c (prod_c)
  );

`ifdef ANC_MAC_SAT_EN
  logic [IDX_W:0] guard_c;

  // In range only when the guard bits and bit 63 are all equal.
  always_comb begin
    guard_c  = acc_q[ACC_W-1:PROD_W-1];
    clip_c   = (|guard_c) && !(&guard_c);
    result_c = acc_q[PROD_W-1:0];
    if (clip_c) begin
      result_c = acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  // Two's-complement wrap to the output width.
  always_comb begin
    result_c = acc_q[PROD_W-1:0];
    clip_c   = 1'b0;
  end
`endif

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    tap_d      = tap_q;
    coef_d     = coef_q;
    y_out_d    = y_out_q;
    y_valid_d  = 1'b0;
    sat_flag_d = 1'b0;
    overrun_d  = overrun_q;

    if (bus.coef_we && (32'(bus.coef_addr) < NTAPS)) begin
      coef_d[IDX_W'(bus.coef_addr)] = bus.coef_data;
    end

    if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.x_valid) begin
          tap_d[0] = bus.x_in;
          for (int unsigned k = 1; k < NTAPS; k++) begin
            tap_d[k] = tap_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod_c);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NTAPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        y_out_d    = result_c;
        y_valid_d  = 1'b1;
        sat_flag_d = clip_c;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (bus.x_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      y_out_q    <= '0;
      y_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      sat_flag_q <= 1'b0;
      for (int unsigned k = 0; k < NTAPS; k++) begin
        tap_q[k]  <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      y_out_q    <= y_out_d;
      y_valid_q  <= y_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      sat_flag_q <= sat_flag_d;
      tap_q      <= tap_d;
      coef_q     <= coef_d;
    end
  end

  assign bus.y_out    = y_out_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;
  assign bus.sat_flag = sat_flag_q;

endmodule

// File: tb/tb_anc_fir_mac.sv
// Scoreboard bench for anc_fir_mac: stimulus pushes expected results, a
// negedge monitor pops and compares on every y_valid.
module tb_anc_fir_mac;
  import anc_pkg::*;

  localparam int unsigned NTAPS = 16;
  localparam logic [63:0] P_MAX = 64'h3FFF_FFFF_0000_0001; // (2^31-1)^2

  typedef struct packed {
    logic [63:0] y;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned vectors = 0;
  int unsigned errors  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  anc_fir_mac_if bus ();

  anc_fir_mac #(.NTAPS(NTAPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [63:0] y, input logic sat);
    exp_t e;
    e.y   = y;
    e.sat = sat;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [31:0] x);
    bus.x_in    = x;
    bus.x_valid = 1'b1;
    tick();
    bus.x_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] x);
    pulse(x);
    repeat (NTAPS + 2) tick();
  endtask

  task automatic write_coef(input logic [7:0] addr, input logic [31:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr;
    bus.coef_data = data;
    tick();
    bus.coef_we = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every output strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (bus.y_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_y: got %h expected no output", bus.y_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("y_out", bus.y_out, e.y);
        check("sat_flag", 64'(bus.sat_flag), 64'(e.sat));
      end
    end
  end

  initial begin
    logic [127:0] full;
    logic         bad;
    bus.x_in = '0; bus.x_valid = 1'b0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_data = '0; bus.clr_ovr = 1'b0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_y_out", bus.y_out, 64'd0);
    check("rst_flags", 64'({bus.y_valid, bus.busy, bus.overrun, bus.sat_flag}), 64'd0);
    rst = 1'b0;
    tick();

    // Impulse: coefs k+1
    for (int k = 0; k < int'(NTAPS); k++) write_coef(8'(k), 32'(k + 1));
    push(64'd1, 1'b0);
    send(32'd1);
    for (int k = 1; k <= int'(NTAPS); k++) begin
      push((k < int'(NTAPS)) ? 64'(k + 1) : 64'd0, 1'b0);
      send(32'd0);
    end

    // Latency / busy window
    push(64'd5, 1'b0);
    pulse(32'd5);
    for (int n = 1; n <= int'(NTAPS) + 3; n++) begin
      @(negedge clk);
      check($sformatf("lat_busy_yv_n%0d", n), 64'({bus.busy, bus.y_valid}),
            64'({(n >= 1 && n <= int'(NTAPS) + 1), (n == int'(NTAPS) + 2)}));
    end
    tick();

    // Overrun: dropped sample leaves line unchanged
    push(64'd12, 1'b0);
    pulse(32'd2);
    tick(); tick();
    bus.x_in = 32'd100; bus.x_valid = 1'b1;
    tick();
    bus.x_valid = 1'b0;
    repeat (NTAPS) tick();
    @(negedge clk);
    check("ovr_set", 64'(bus.overrun), 64'd1);
    push(64'd19, 1'b0);
    send(32'd0);
    bus.clr_ovr = 1'b1; tick(); bus.clr_ovr = 1'b0;
    @(negedge clk);
    check("ovr_clr", 64'(bus.overrun), 64'd0);
    push(64'd26, 1'b0);
    pulse(32'd0);
    tick();
    bus.x_valid = 1'b1; bus.clr_ovr = 1'b1;
    tick();
    bus.x_valid = 1'b0; bus.clr_ovr = 1'b0;
    @(negedge clk);
    check("ovr_drop_wins", 64'(bus.overrun), 64'd1);
    repeat (NTAPS) tick();
    bus.clr_ovr = 1'b1; tick(); bus.clr_ovr = 1'b0;
    @(negedge clk);
    check("ovr_clr2", 64'(bus.overrun), 64'd0);
    tick();

    // Saturation / wrap with full-scale positive operands
    do_reset();
    for (int k = 0; k < int'(NTAPS); k++) write_coef(8'(k), 32'h7FFF_FFFF);
    for (int j = 0; j < int'(NTAPS); j++) begin
      full = 128'(j + 1) * 128'(P_MAX);
`ifdef ANC_MAC_SAT_EN
      if (full > 128'h7FFF_FFFF_FFFF_FFFF) push(SAT_MAX, 1'b1);
      else push(full[63:0], 1'b0);
`else
      push(full[63:0], 1'b0);
`endif
      send(32'h7FFF_FFFF);
    end

    // Reset mid-MAC
    pulse(32'd1);
    tick();
    bus.x_valid = 1'b1; tick(); bus.x_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_ovr", 64'(bus.overrun), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_y_out", bus.y_out, 64'd0);
    check("midrst_flags", 64'({bus.y_valid, bus.busy, bus.overrun, bus.sat_flag}), 64'd0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (NTAPS + 4) begin
      @(negedge clk);
      if (bus.y_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    check("midrst_quiet", 64'(bad), 64'd0);
    tick();
    write_coef(8'd0, 32'd2);
    write_coef(8'd1, 32'd3);
    push(64'd14, 1'b0);
    send(32'd7);
    push(64'd21, 1'b0);
    send(32'd0);

    // Negative full scale; out-of-range coef address ignored
    do_reset();
    write_coef(8'd0, 32'h8000_0000);
    write_coef(8'd24, 32'd7);
    push(64'h4000_0000_0000_0000, 1'b0);
    send(32'h8000_0000);
    for (int k = 0; k < 8; k++) begin
      push(64'd0, 1'b0);
      send(32'd0);
    end

    // Coef write colliding with its own MAC read uses the old value
    do_reset();
    write_coef(8'd0, 32'd3);
    push(64'd12, 1'b0);
    pulse(32'd4);
    bus.coef_we = 1'b1; bus.coef_addr = 8'd0; bus.coef_data = 32'd100;
    tick();
    bus.coef_we = 1'b0;
    repeat (NTAPS + 1) tick();
    push(64'd0, 1'b0);
    send(32'd0);
    push(64'd100, 1'b0);
    send(32'd1);

    repeat (5) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
